seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: accepts a 20-bit unsigned value, converts it to six BCD digits
// with a serial double-dabble engine, and multiplexes the digits onto a
// six-digit 7-segment display (active-low digit enables).
// Optional build macro SEG_LZ_BLANK_EN enables leading-zero blanking.
module seg_scan_ctrl #(
    parameter int SCAN_DIV = 69_444,
    parameter int VAL_W    = 20
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [VAL_W-1:0] val_in,
    input  logic             val_valid,
    output logic             val_ready,
    output logic [3:0]       num,
    output logic [5:0]       sel,
    output logic             ovf
);

    localparam int                 DIV_W    = 20;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [VAL_W-1:0]   MAX_VAL  = VAL_W'(999_999);
    localparam logic [4:0]         LAST_STEP = 5'd19;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LOAD
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [4:0]        step;
    logic              accept;

    logic [23:0]       bcd;
    logic [VAL_W-1:0]  bin;
    logic              ovf_pend;

    logic [23:0]       disp;
    logic [23:0]       disp_next;

    logic [DIV_W-1:0]  div_cnt;
    logic [2:0]        idx;
    logic [2:0]        idx_next;
    logic              slot_adv;

    // Values above six decimal digits are pinned to 999999.
    function automatic logic [VAL_W-1:0] clamp_val(input logic [VAL_W-1:0] v);
        return (v > MAX_VAL) ? MAX_VAL : v;
    endfunction

    // Add-3 correction applied to every BCD nibble before the shift.
    function automatic logic [23:0] dabble_adjust(input logic [23:0] b);
        logic [23:0] r;
        r = b;
        for (int i = 0; i < 6; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Index of the most significant nonzero digit; 0 when the value is zero.
    function automatic logic [2:0] msd_index(input logic [23:0] d);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 1; i < 6; i++) begin
            if (d[i*4 +: 4] != 4'd0) begin
                r = 3'(i);
            end
        end
        return r;
    endfunction

    // Active-low enable for a slot, optionally blanking leading zeros.
    function automatic logic [5:0] slot_sel(input logic [2:0] slot, input logic [23:0] d);
        logic [5:0] r;
        r = ~(6'b000001 << slot);
`ifdef SEG_LZ_BLANK_EN
        if (slot > msd_index(d)) begin
            r = 6'b111111;
        end
`else
        if (d == 24'd0 && slot == 3'd7) begin
            r = 6'b111111;
        end
`endif
        return r;
    endfunction

    assign accept = val_valid && val_ready;

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: capture in IDLE, 20 shift steps in CONV, one LOAD edge.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CONV;
            CONV:    if (step == LAST_STEP) state_next = LOAD;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and step counter; ready is held low through reset.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            val_ready <= 1'b0;
            step      <= 5'd0;
        end else begin
            val_ready <= (state_next == IDLE);
            if (accept) begin
                step <= 5'd0;
            end else if (state == CONV) begin
                step <= step + 5'd1;
            end
        end
    end

    // Conversion datapath: load clamped value, then one double-dabble step per cycle.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            bcd      <= 24'd0;
            bin      <= clamp_val(val_in);
            ovf_pend <= (val_in > MAX_VAL);
        end else if (state == CONV) begin
            {bcd, bin} <= {dabble_adjust(bcd), bin} << 1;
        end
    end

    assign disp_next = (state == LOAD) ? bcd : disp;

    // Display registers take the finished digits in LOAD only.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            disp <= 24'd0;
            ovf  <= 1'b0;
        end else if (state == LOAD) begin
            disp <= bcd;
            ovf  <= ovf_pend;
        end
    end

    assign slot_adv = (div_cnt == DIV_LAST);
    assign idx_next = (idx == 3'd5) ? 3'd0 : idx + 3'd1;

    // Scan divider and slot index, free-running and independent of conversion.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= 3'd0;
        end else if (slot_adv) begin
            div_cnt <= '0;
            idx     <= idx_next;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Digit outputs change only on a slot advance, using same-edge LOAD data.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sel <= 6'b111111;
            num <= 4'd0;
        end else if (slot_adv) begin
            sel <= slot_sel(idx_next, disp_next);
            num <= disp_next[idx_next*4 +: 4];
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with SCAN_DIV=4. Expected slot
// contents come from a decimal model pushed into a scoreboard queue at
// stimulus time and popped when the scanned outputs are captured.
module tb_seg_scan_ctrl;

    localparam int SCAN_DIV = 4;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] val_in = 20'd0;
    logic        val_valid = 1'b0;
    logic        val_ready;
    logic [3:0]  num;
    logic [5:0]  sel;
    logic        ovf;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [5:0] s;
        logic [3:0] n;
    } slot_t;

    slot_t      exp_q[$];
    logic [5:0] got_sel[6];
    logic [3:0] got_num[6];
    bit         seen_seven = 1'b0;

    seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .VAL_W(20)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .val_in    (val_in),
        .val_valid (val_valid),
        .val_ready (val_ready),
        .num       (num),
        .sel       (sel),
        .ovf       (ovf)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (num == 4'd7) seen_seven = 1'b1;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_expected(input int unsigned v);
        int unsigned c;
        int          d[6];
        int          msd;
        slot_t       e;
        c = (v > 999999) ? 999999 : v;
        msd = 0;
        for (int i = 0; i < 6; i++) begin
            d[i] = int'(c % 10);
            c = c / 10;
        end
        for (int i = 1; i < 6; i++) if (d[i] != 0) msd = i;
        for (int i = 0; i < 6; i++) begin
            e.n = 4'(d[i]);
            e.s = ~(6'b000001 << i);
`ifdef SEG_LZ_BLANK_EN
            if (i > msd) e.s = 6'b111111;
`endif
            exp_q.push_back(e);
        end
    endtask

    task automatic do_accept(input logic [19:0] v, output bit ok);
        ok = 1'b0;
        val_in = v;
        val_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (val_ready === 1'b1) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        val_valid = 1'b0;
    endtask

    task automatic wait_done(output int low);
        low = 0;
        while (val_ready !== 1'b1 && low < 60) begin
            low++;
            tick();
        end
    endtask

    task automatic capture_scan(output bit ok);
        logic [5:0] prev;
        ok = 1'b0;
        prev = sel;
        for (int i = 0; i < 8 * SCAN_DIV + 8; i++) begin
            tick();
            if (sel == 6'b111110 && prev != 6'b111110) begin
                ok = 1'b1;
                break;
            end
            prev = sel;
        end
        if (ok) begin
            got_sel[0] = sel;
            got_num[0] = num;
            for (int k = 1; k < 6; k++) begin
                repeat (SCAN_DIV) tick();
                got_sel[k] = sel;
                got_num[k] = num;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (sel !== 6'b111111 || num !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: sel=%b num=%0d, required sel=111111 num=0", sel, num);
            end
            n_checks++;
            if (val_ready !== 1'b0 || ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ready_ovf: val_ready=%b ovf=%b, required 0 0", val_ready, ovf);
            end
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (val_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: val_ready=%b, required 1", val_ready);
        end
    endtask

    task automatic test_convert(input string name, input logic [19:0] v, input logic exp_ovf);
        bit    ok;
        int    low;
        slot_t e;
        push_expected(int'(v));
        do_accept(v, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_accept: val_ready never high, required accept", name);
        end
        wait_done(low);
        n_checks++;
        if (low != 21) begin
            n_fail++;
            $display("FAIL %s_busy_cycles: %0d cycles low, required 21", name, low);
        end
        n_checks++;
        if (ovf !== exp_ovf) begin
            n_fail++;
            $display("FAIL %s_ovf: ovf=%b, required %b", name, ovf, exp_ovf);
        end
        capture_scan(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_scan_timeout: slot 0 never seen, required scan", name);
        end
        for (int k = 0; k < 6; k++) begin
            e = exp_q.pop_front();
            if (ok) begin
                n_checks++;
                if (got_sel[k] !== e.s || got_num[k] !== e.n) begin
                    n_fail++;
                    $display("FAIL %s_slot%0d: sel=%b num=%0d, required sel=%b num=%0d",
                             name, k, got_sel[k], got_num[k], e.s, e.n);
                end
            end
        end
    endtask

    task automatic test_ignore_during_conv();
        bit    ok;
        int    low;
        slot_t e;
        push_expected(111111);
        do_accept(20'd111111, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ignore_accept: val_ready never high, required accept");
        end
        val_in = 20'd222222;
        for (int i = 0; i < 8; i++) begin
            val_valid = (i % 3) != 2;
            n_checks++;
            if (val_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL ignore_ready_low: val_ready=%b at cycle %0d, required 0", val_ready, i);
            end
            tick();
        end
        val_valid = 1'b0;
        wait_done(low);
        n_checks++;
        if (low + 8 != 21) begin
            n_fail++;
            $display("FAIL ignore_busy_cycles: %0d cycles low, required 21", low + 8);
        end
        capture_scan(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ignore_scan_timeout: slot 0 never seen, required scan");
        end
        for (int k = 0; k < 6; k++) begin
            e = exp_q.pop_front();
            if (ok) begin
                n_checks++;
                if (got_sel[k] !== e.s || got_num[k] !== e.n) begin
                    n_fail++;
                    $display("FAIL ignore_slot%0d: sel=%b num=%0d, required sel=%b num=%0d",
                             k, got_sel[k], got_num[k], e.s, e.n);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        bit    ok;
        slot_t e;
        do_accept(20'd777777, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL abort_accept: val_ready never high, required accept");
        end
        repeat (10) tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (val_ready !== 1'b0 || sel !== 6'b111111 || num !== 4'd0) begin
            n_fail++;
            $display("FAIL abort_in_reset: ready=%b sel=%b num=%0d, required 0 111111 0", val_ready, sel, num);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (val_ready !== 1'b1 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_release: ready=%b ovf=%b, required 1 0", val_ready, ovf);
        end
        push_expected(0);
        capture_scan(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL abort_scan_timeout: slot 0 never seen, required scan");
        end
        for (int k = 0; k < 6; k++) begin
            e = exp_q.pop_front();
            if (ok) begin
                n_checks++;
                if (got_sel[k] !== e.s || got_num[k] !== e.n) begin
                    n_fail++;
                    $display("FAIL abort_slot%0d: sel=%b num=%0d, required sel=%b num=%0d",
                             k, got_sel[k], got_num[k], e.s, e.n);
                end
            end
        end
        n_checks++;
        if (seen_seven) begin
            n_fail++;
            $display("FAIL abort_no_777777: digit 7 displayed, required never");
        end
    endtask

    initial begin
        test_reset();
        test_convert("basic", 20'd123456, 1'b0);
        test_convert("overflow", 20'd1048575, 1'b1);
        test_convert("ovf_clear", 20'd5, 1'b0);
        test_convert("blank42", 20'd42, 1'b0);
        test_ignore_during_conv();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
